// File: rtl/gauss_pkg.sv
// Shared constants and arithmetic helpers for the 3x3 Gaussian blur stage.
// Kernel is [1 2 1; 2 4 2; 1 2 1]/16, applied as row sums then a column sum.
package gauss_pkg;

    localparam int DW     = 8;     // pixel width
    localparam int MAX_W  = 1920;  // deepest supported line
    localparam int CNT_W  = 11;    // row/col counter, IH/IW and line-buffer address width
    localparam int LAT    = 3;     // pi_flag sample edge to po_flag
    localparam int ROW_W  = 10;    // a+2b+c, max 1020
    localparam int SUM_W  = 12;    // r0+2*r1+r2, max 4080
    localparam int MIN_SZ = 3;     // smallest legal IH / IW
    localparam int K_SIDE = 1;     // outer kernel tap
    localparam int K_CTR  = 2;     // centre kernel tap (per axis)
    localparam int SHIFT  = 4;     // divide by 16
    localparam int RND    = 8;     // round half up before the shift

    function automatic logic [ROW_W-1:0] row_sum(input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b,
                                                 input logic [DW-1:0] c);
        return ROW_W'(K_SIDE) * ROW_W'(a) + ROW_W'(K_CTR) * ROW_W'(b) + ROW_W'(K_SIDE) * ROW_W'(c);
    endfunction

    function automatic logic [SUM_W-1:0] col_sum(input logic [ROW_W-1:0] r0,
                                                 input logic [ROW_W-1:0] r1,
                                                 input logic [ROW_W-1:0] r2);
        return SUM_W'(K_SIDE) * SUM_W'(r0) + SUM_W'(K_CTR) * SUM_W'(r1) + SUM_W'(K_SIDE) * SUM_W'(r2);
    endfunction

endpackage

// File: rtl/gauss_line_buf.sv
// One line of pixel storage: single-clock simple dual-port RAM with
// read-before-write at a shared address (rdata shows the old word during
// the cycle that overwrites it).
//   clk   : system clock
//   we    : write strobe
//   addr  : shared read/write address (column)
//   wdata : word written on we
//   rdata : word currently stored at addr
module gauss_line_buf
    import gauss_pkg::*;
#(
    parameter int DEPTH  = MAX_W,
    parameter int WIDTH  = DW,
    parameter int ADDR_W = CNT_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/gauss_blur3x3.sv
// 3x3 Gaussian smoothing of a raster grey stream ahead of the Canny stage.
// Output frame is cropped by one pixel on every border.
//   clk, rst          : system clock, synchronous active-high reset
//   pi_flag, pi_data  : input pixel valid / grey value, raster order, gaps allowed
//   IH, IW            : frame height / width, latched on the first pixel of a frame
//   po_flag, po_data  : blurred pixel valid / value, LAT clocks after the enabling pixel
//   frame_done        : pulse with the last output pixel of a frame
//   size_err          : sticky, a frame started with an out-of-range size
module gauss_blur3x3
    import gauss_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             pi_flag,
    input  logic [DW-1:0]    pi_data,
    input  logic [CNT_W-1:0] IH,
    input  logic [CNT_W-1:0] IW,
    output logic             po_flag,
    output logic [DW-1:0]    po_data,
    output logic             frame_done,
    output logic             size_err
);

    // Input register: the line-buffer read is combinational, so this stage
    // supplies the first of the LAT clocks. IH/IW travel with the pixel so
    // the latch sees the values present when pi_flag was sampled.
    logic             in_flag;
    logic [DW-1:0]    in_data;
    logic [CNT_W-1:0] in_ih, in_iw;

    always_ff @(posedge clk) begin
        if (rst) in_flag <= 1'b0;
        else     in_flag <= pi_flag;
    end

    always_ff @(posedge clk) begin
        in_data <= pi_data;
        in_ih   <= IH;
        in_iw   <= IW;
    end

    // Position counters and per-frame size latch
    logic [CNT_W-1:0] col, row, lat_ih, lat_iw;
    logic             lat_bad;
    logic             first, cur_bad, col_end, row_end, we, tag_vld, tag_last;
    logic [CNT_W-1:0] cur_ih, cur_iw;

    always_comb begin
        first    = (col == '0) && (row == '0);
        cur_ih   = first ? in_ih : lat_ih;
        cur_iw   = first ? in_iw : lat_iw;
        cur_bad  = first ? (in_iw > CNT_W'(MAX_W) || in_iw < CNT_W'(MIN_SZ) || in_ih < CNT_W'(MIN_SZ))
                         : lat_bad;
        col_end  = (col == cur_iw - CNT_W'(1));
        row_end  = (row == cur_ih - CNT_W'(1));
        // A bad frame never writes the RAM, so an oversize col cannot land
        // outside it; counters keep running so the next frame resyncs.
        we       = in_flag && !cur_bad;
        tag_vld  = we && (row >= CNT_W'(2)) && (col >= CNT_W'(2));
        tag_last = col_end && row_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            lat_ih   <= '0;
            lat_iw   <= '0;
            lat_bad  <= 1'b0;
            size_err <= 1'b0;
        end else if (in_flag) begin
            if (first) begin
                lat_ih  <= in_ih;
                lat_iw  <= in_iw;
                lat_bad <= cur_bad;
                if (cur_bad) size_err <= 1'b1;
            end
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    // Line buffers: lb0 holds row-2, lb1 holds row-1; lb1's old word cascades into lb0
    logic [DW-1:0] lb0_q, lb1_q;

    gauss_line_buf #(.DEPTH(MAX_W), .WIDTH(DW), .ADDR_W(CNT_W)) u_lb0 (
        .clk   (clk),
        .we    (we),
        .addr  (col),
        .wdata (lb1_q),
        .rdata (lb0_q)
    );

    gauss_line_buf #(.DEPTH(MAX_W), .WIDTH(DW), .ADDR_W(CNT_W)) u_lb1 (
        .clk   (clk),
        .we    (we),
        .addr  (col),
        .wdata (in_data),
        .rdata (lb1_q)
    );

    // S1: 3x3 window, newest column at index 2
    logic [DW-1:0] win [3][3];

    always_ff @(posedge clk) begin
        if (in_flag) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb0_q;
            win[1][2] <= lb1_q;
            win[2][2] <= in_data;
        end
    end

    // S2: horizontal row sums
    logic [ROW_W-1:0] rs0, rs1, rs2;

    always_ff @(posedge clk) begin
        rs0 <= row_sum(win[0][0], win[0][1], win[0][2]);
        rs1 <= row_sum(win[1][0], win[1][1], win[1][2]);
        rs2 <= row_sum(win[2][0], win[2][1], win[2][2]);
    end

    // S3: vertical sum, round, divide
    logic [SUM_W-1:0] total;

    always_comb begin
        total = col_sum(rs0, rs1, rs2);
    end

    always_ff @(posedge clk) begin
        if (rst) po_data <= '0;
        else     po_data <= DW'((total + SUM_W'(RND)) >> SHIFT);
    end

    // Valid / last tags ride alongside S1..S3; reset drops anything in flight
    logic [LAT-1:0] vld_sr, last_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr  <= {vld_sr[LAT-2:0], tag_vld};
            last_sr <= {last_sr[LAT-2:0], tag_last};
        end
    end

    assign po_flag    = vld_sr[LAT-1];
    assign frame_done = vld_sr[LAT-1] & last_sr[LAT-1];

endmodule

// File: tb/tb_gauss_blur3x3.sv
module tb_gauss_blur3x3;

    logic        clk = 1'b0;
    logic        rst, pi_flag;
    logic [7:0]  pi_data;
    logic [10:0] IH, IW;
    logic        po_flag;
    logic [7:0]  po_data;
    logic        frame_done, size_err;

    always #5 clk = ~clk;

    gauss_blur3x3 dut (
        .clk        (clk),
        .rst        (rst),
        .pi_flag    (pi_flag),
        .pi_data    (pi_data),
        .IH         (IH),
        .IW         (IW),
        .po_flag    (po_flag),
        .po_data    (po_data),
        .frame_done (frame_done),
        .size_err   (size_err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_out  = 0;
    int base;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        int t;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pix [0:31][0:31];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Blurred value centred at (r,c): weighted neighbourhood sum / 16, rounded half up
    function automatic int ref_px(input int r, input int c);
        int s = 0;
        for (int i = -1; i <= 1; i++)
            for (int j = -1; j <= 1; j++)
                s += ((i == 0) ? 2 : 1) * ((j == 0) ? 2 : 1) * pix[r+i][c+j];
        return (s + 8) / 16;
    endfunction

    task automatic fill(input int val);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                pix[r][c] = val;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                pix[r][c] = int'($urandom_range(255, 0));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            pi_flag = 1'b0;
        end
    endtask

    // Drives rows [0, stop_row) of an h x w frame from pix[][]; IH/IW hold the
    // real size only on the first pixel and are scrambled afterwards.
    task automatic drive_frame(input int h, input int w, input int max_gap, input int stop_row);
        bit ok;
        ok = (h >= 3) && (w >= 3) && (w <= 1920);
        for (int r = 0; r < stop_row; r++) begin
            for (int c = 0; c < w; c++) begin
                repeat ($urandom_range(max_gap, 0)) begin
                    @(posedge clk); #1;
                    pi_flag = 1'b0;
                end
                @(posedge clk); #1;
                pi_flag = 1'b1;
                pi_data = 8'(pix[r][c]);
                if (r == 0 && c == 0) begin
                    IH = 11'(h);
                    IW = 11'(w);
                end else begin
                    IH = 11'($urandom);
                    IW = 11'($urandom);
                end
                if (ok && r >= 2 && c >= 2)
                    exp_q.push_back('{ref_px(r-1, c-1), cyc + 4, (r == h-1) && (c == w-1)});
            end
        end
    endtask

    always @(negedge clk) begin
        if (po_flag) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_po_flag", po_flag, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("po_data", po_data, mon_e.data);
                check_eq("po_time", cyc, mon_e.t);
                check_eq("frame_done", frame_done, mon_e.last);
            end
        end else if (frame_done) begin
            check_eq("frame_done_without_po", frame_done, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d pending outputs", exp_q.size());
        $fatal(1);
    end

    initial begin
        int h, w, g, tot;
        rst = 1'b1; pi_flag = 1'b0; pi_data = '0; IH = 11'd5; IW = 11'd5;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("rst_po_flag", po_flag, 0);
        check_eq("rst_po_data", po_data, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_size_err", size_err, 0);

        // Constant frame
        fill(100); base = n_out;
        drive_frame(5, 5, 0, 5); idle(8);
        check_eq("const_count", n_out - base, 9);

        // Impulse
        fill(0); pix[2][2] = 160; base = n_out;
        drive_frame(5, 5, 0, 5); idle(8);
        check_eq("impulse_count", n_out - base, 9);

        // Rounding at the corner tap: 8/16 rounds up, 7/16 rounds down
        fill(0); pix[0][0] = 8;
        drive_frame(5, 5, 0, 5);
        pix[0][0] = 7;
        drive_frame(5, 5, 0, 5); idle(8);

        // Gapped impulse
        fill(0); pix[2][2] = 160; base = n_out;
        drive_frame(5, 5, 5, 5); idle(8);
        check_eq("gapped_count", n_out - base, 9);

        // Reset in the middle of a 6x6 frame, then a clean 5x5 frame
        fill_rand();
        drive_frame(6, 6, 0, 3);
        @(posedge clk); #1;
        pi_flag = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check_eq("midrst_po_flag", po_flag, 0);
        check_eq("midrst_po_data", po_data, 0);
        fill(50); base = n_out;
        drive_frame(5, 5, 0, 5); idle(8);
        check_eq("after_rst_count", n_out - base, 9);

        // Back-to-back size change 5x5 -> 4x7
        fill_rand(); base = n_out;
        drive_frame(5, 5, 0, 5);
        fill_rand();
        drive_frame(4, 7, 0, 4); idle(8);
        check_eq("b2b_count", n_out - base, 19);
        check_eq("size_err_clear", size_err, 0);

        // Width 2: flagged, silent, counters still resync for the next frame
        fill_rand(); base = n_out;
        drive_frame(5, 2, 0, 5); idle(8);
        check_eq("bad_count", n_out - base, 0);
        check_eq("size_err_set", size_err, 1);
        fill_rand(); base = n_out;
        drive_frame(4, 4, 0, 4); idle(8);
        check_eq("resync_count", n_out - base, 4);
        check_eq("size_err_sticky", size_err, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_eq("size_err_rst", size_err, 0);

        // Random frames, random sizes and gaps, back to back
        base = n_out; tot = 0;
        for (int k = 0; k < 6; k++) begin
            h = int'($urandom_range(10, 3));
            w = int'($urandom_range(12, 3));
            g = int'($urandom_range(3, 0));
            fill_rand();
            drive_frame(h, w, g, h);
            tot += (h - 2) * (w - 2);
        end
        idle(8);
        check_eq("random_count", n_out - base, tot);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gauss_blur3x3.md
Name: gauss_blur3x3

Overview:
- Noise-suppression stage directly upstream of the Canny edge detector.
- Takes the raster 8-bit grey stream (pi_flag/pi_data) and applies a 3x3 Gaussian kernel [1 2 1; 2 4 2; 1 2 1]/16 over a sliding window built from two line buffers.
- Emits the smoothed stream (po_flag/po_data) for the Canny stage.
- Output frame is cropped by one pixel on each border (valid windows only). Canny is driven with IH-2, IW-2.

Parameters:
- MAX_W, 1920, maximum supported line width; sets line-buffer depth.
- DW, 8, pixel width.
- LAT, 3, pixel latency, pi_flag sample to po_flag; fixed, informational.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pi_flag  in  1  input pixel valid; gaps allowed anywhere
- pi_data  in  8  input grey pixel, raster order
- IH  in  11  frame height in lines, ≥3
- IW  in  11  frame width in pixels, 3..MAX_W
- po_flag  out  1  output pixel valid
- po_data  out  8  blurred pixel
- frame_done  out  1  one-cycle pulse coincident with the last output pixel of a frame
- size_err  out  1  sticky flag: a frame started with IW>MAX_W, IW<3 or IH<3; cleared only by rst

Behaviour:
- Reset values: po_flag=0, po_data=0, frame_done=0, size_err=0. Column, row and pipeline-valid registers are cleared. Line-buffer RAM is not cleared; stale contents are masked by row gating.
- IH/IW are latched on the first accepted pixel of each frame (col=0, row=0). Changes mid-frame are ignored.
- Counters:
  - col advances only on pi_flag. At latched IW-1 it wraps to 0 and row increments.
  - At (IH-1, IW-1), both counters return to 0 and the next pixel starts a new frame.
- Line buffers:
  - Two buffers, read-before-write at address col.
  - On pi_flag: lb1 output is written into lb0, pi_data is written into lb1, and both old values are read.
  - The column {lb0_old, lb1_old, pi_data} shifts into the 3x3 window register. The window shifts only on pi_flag.
- Window validity: an accepted pixel at (row, col) with row≥2 and col≥2 completes a valid window centred at (row-1, col-1). Otherwise no output is produced for that pixel.
- Pipeline (advances every cycle; valid bit travels with the data):
  - S1: window update and valid tag.
  - S2: row sums a+2b+c, 10 bits each.
  - S3: total r0+2·r1+r2 (12 bits, max 4080), then (total+8)>>4 registered into po_data with po_flag.
  - po_flag rises exactly 3 clk after the edge that sampled the pixel's pi_flag.
  - No saturation is needed: max result is 255.
- Output count per frame: exactly (IH-2)·(IW-2) po_flag pulses, in raster order. There are no output gaps beyond the input gaps.
- frame_done is asserted with the po_flag for input pixel (IH-1, IW-1).
- Bad size:
  - If the latched IW/IH is out of range, size_err is set and that frame produces no po_flag.
  - Counters still track so the next frame can resynchronise.
- Reset mid-frame:
  - Everything listed above returns to its reset value on the next clk.
  - In-flight pipeline outputs are dropped.
  - The next accepted pixel is treated as (0,0).
- Back-to-back frames: the first pixel of frame N+1 may arrive the cycle after the last pixel of frame N. Frame N's last outputs still drain correctly.

Decomposition:
- Package gauss_pkg: DW, MAX_W, kernel weights, shift constant 4, rounding constant 8, LAT, width constants (ROW_W=10, SUM_W=12), min-size constant 3.
- Sub-module gauss_line_buf: single-clock simple dual-port RAM, MAX_W×DW, read-before-write at the same address, write enable = pi_flag. Instantiated twice.
- Counters, window, adder pipeline and control stay in gauss_blur3x3.

Test Plan:
- Constant frame: 5×5, all pixels 100, continuous pi_flag. Expect 9 outputs of 100, first po_flag 3 clk after pixel (2,2), frame_done with the 9th.
- Impulse: 5×5 zeros, pixel (2,2)=160. Expect a 3×3 output of 10,20,10 / 20,40,20 / 10,20,10.
- Rounding: 5×5 zeros with corner-weight pixel (0,0)=8 then a repeat with 7. The first output is 1, then 0; all others are 0.
- Gapped input: impulse frame with random pi_flag low gaps of 0–5 cycles. Outputs are identical, each 3 clk after its enabling pixel.
- Reset mid-frame: assert rst at row 3 of a 6×6 frame, then send a fresh 5×5 constant-50 frame. Expect no stale outputs and exactly 9 outputs of 50.
- Size changes: back-to-back frames 5×5 then 4×7, no idle cycle between them. Expect 9 then 10 outputs, correct values. Then a frame with IW=2 sets size_err and produces no outputs.
